// File: rtl/result_packer.sv
// Serialises logic_control result records (markers, ADC samples, timestamps) into 16-bit
// FIFO words: a header carrying type/device/address/sequence, followed by the payload words.
module result_packer #(
   parameter int ADC_WIDTH  = 14,
   parameter int TIME_WIDTH = 48
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rec_valid,
   output logic                  rec_ready,
   input  logic [1:0]            rec_type,
   input  logic [3:0]            rec_dev,
   input  logic [7:0]            rec_addr,
   input  logic [ADC_WIDTH-1:0]  rec_adc,
   input  logic [TIME_WIDTH-1:0] rec_time,
   input  logic                  fifo_full,
   output logic [15:0]           data_out,
   output logic                  data_out_en,
   output logic                  busy,
   output logic [15:0]           word_cnt
);

   localparam int TimeWords = TIME_WIDTH / 16;
   localparam int MaxWords  = 2 + TimeWords;
   localparam int IdxW      = $clog2(MaxWords);

   typedef enum logic {
      IDLE,
      EMIT
   } state_t;

   state_t                state_q, state_d;
   logic [1:0]            type_q, type_d;
   logic [15:0]           header_q, header_d;
   logic [15:0]           adc_q, adc_d;
   logic [TIME_WIDTH-1:0] time_q, time_d;
   logic [IdxW-1:0]       idx_q, idx_d;
   logic [IdxW-1:0]       lastIdx_q, lastIdx_d;
   logic [1:0]            seq_q, seq_d;
   logic [15:0]           dataOut_q, dataOut_d;
   logic                  dataOutEn_q, dataOutEn_d;
   logic [15:0]           wordCnt_q, wordCnt_d;

   logic [IdxW-1:0]       timeIdx;
   logic [TIME_WIDTH-1:0] timeShifted;
   logic [15:0]           curWord;

   // Word order within a record is header, then ADC (if present), then time MS word first.
   always_comb begin
      timeIdx     = idx_q - IdxW'(1) - IdxW'(type_q[0]);
      timeShifted = time_q << {timeIdx, 4'b0000};
      if (idx_q == '0) begin
         curWord = header_q;
      end else if (type_q[0] && (idx_q == IdxW'(1))) begin
         curWord = adc_q;
      end else begin
         curWord = timeShifted[TIME_WIDTH-1 -: 16];
      end
   end

   always_comb begin
      state_d     = state_q;
      type_d      = type_q;
      header_d    = header_q;
      adc_d       = adc_q;
      time_d      = time_q;
      idx_d       = idx_q;
      lastIdx_d   = lastIdx_q;
      seq_d       = seq_q;
      dataOut_d   = dataOut_q;
      dataOutEn_d = 1'b0;
      wordCnt_d   = wordCnt_q;
      case (state_q)
         IDLE: begin
            if (rec_valid) begin
               type_d    = rec_type;
               header_d  = {rec_type, rec_dev, rec_addr, seq_q};
               adc_d     = 16'(rec_adc);
               time_d    = rec_time;
               idx_d     = '0;
               lastIdx_d = IdxW'(rec_type[0]) + (rec_type[1] ? IdxW'(TimeWords) : '0);
               seq_d     = seq_q + 2'd1;
               state_d   = EMIT;
            end
         end
         EMIT: begin
            // A full FIFO simply stalls the index; the held data_out is never re-strobed.
            if (!fifo_full) begin
               dataOut_d   = curWord;
               dataOutEn_d = 1'b1;
               wordCnt_d   = wordCnt_q + 16'd1;
               idx_d       = idx_q + IdxW'(1);
               if (idx_q == lastIdx_q) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         type_q      <= '0;
         header_q    <= '0;
         adc_q       <= '0;
         time_q      <= '0;
         idx_q       <= '0;
         lastIdx_q   <= '0;
         seq_q       <= '0;
         dataOut_q   <= '0;
         dataOutEn_q <= 1'b0;
         wordCnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         type_q      <= type_d;
         header_q    <= header_d;
         adc_q       <= adc_d;
         time_q      <= time_d;
         idx_q       <= idx_d;
         lastIdx_q   <= lastIdx_d;
         seq_q       <= seq_d;
         dataOut_q   <= dataOut_d;
         dataOutEn_q <= dataOutEn_d;
         wordCnt_q   <= wordCnt_d;
      end
   end

   assign rec_ready   = (state_q == IDLE) & ~rst;
   assign busy        = (state_q == EMIT);
   assign data_out    = dataOut_q;
   assign data_out_en = dataOutEn_q;
   assign word_cnt    = wordCnt_q;

endmodule

// File: tb/tb_result_packer.sv
// Bench for result_packer: directed records with hand-computed words pushed to a scoreboard
// queue, popped by an independent monitor whenever data_out_en is seen.
module tb_result_packer;

   logic        clk;
   logic        rst;
   logic        recValid;
   logic        recReady;
   logic [1:0]  recType;
   logic [3:0]  recDev;
   logic [7:0]  recAddr;
   logic [13:0] recAdc;
   logic [47:0] recTime;
   logic        fifoFull;
   logic [15:0] dataOut;
   logic        dataOutEn;
   logic        busy;
   logic [15:0] wordCnt;

   int          testsRun = 0;
   int          testsFailed = 0;
   int          cycle = 0;
   logic [15:0] expQ[$];
   int          popCycles[$];

   result_packer #(.ADC_WIDTH(14), .TIME_WIDTH(48)) dut (
      .clk        (clk),
      .rst        (rst),
      .rec_valid  (recValid),
      .rec_ready  (recReady),
      .rec_type   (recType),
      .rec_dev    (recDev),
      .rec_addr   (recAddr),
      .rec_adc    (recAdc),
      .rec_time   (recTime),
      .fifo_full  (fifoFull),
      .data_out   (dataOut),
      .data_out_en(dataOutEn),
      .busy       (busy),
      .word_cnt   (wordCnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle++;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every strobed word must match the head of the expected queue.
   always @(negedge clk) begin
      if (dataOutEn) begin
         popCycles.push_back(cycle);
         testsRun++;
         if (expQ.size() == 0) begin
            testsFailed++;
            $display("[TB] FAIL word: got unexpected 0x%04h, expected none", dataOut);
         end else begin
            logic [15:0] e;
            e = expQ.pop_front();
            if (dataOut !== e) begin
               testsFailed++;
               $display("[TB] FAIL word: got 0x%04h, expected 0x%04h", dataOut, e);
            end
         end
      end
   end

   task automatic applyStimulus(input logic [1:0] t, input logic [3:0] d, input logic [7:0] a,
                                input logic [13:0] adc, input logic [47:0] tm,
                                input logic [79:0] expWords, input int n);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!recReady && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (!recReady) begin
         checkOutput("ready_timeout", 32'(recReady), 32'd1);
      end
      recType  = t;
      recDev   = d;
      recAddr  = a;
      recAdc   = adc;
      recTime  = tm;
      recValid = 1'b1;
      for (int i = 0; i < n; i++) begin
         expQ.push_back(expWords[79-16*i -: 16]);
      end
      @(posedge clk);
      #1;
      recValid = 1'b0;
   endtask

   task automatic waitIdle();
      int guard;
      guard = 0;
      @(negedge clk);
      while ((expQ.size() != 0 || busy) && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("drain", 32'(expQ.size()), 32'd0);
   endtask

   initial begin
      rst      = 1'b1;
      recValid = 1'b0;
      recType  = '0;
      recDev   = '0;
      recAddr  = '0;
      recAdc   = '0;
      recTime  = '0;
      fifoFull = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_ready", 32'(recReady), 32'd0);
      checkOutput("rst_en", 32'(dataOutEn), 32'd0);
      checkOutput("rst_data", 32'(dataOut), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_cnt", 32'(wordCnt), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("idle_ready", 32'(recReady), 32'd1);

      // ADC record, seq 0, ready low for exactly two cycles
      applyStimulus(2'd1, 4'd3, 8'h15, 14'h1ABC, 48'h0,
                    {16'h4C54, 16'h1ABC, 48'h0}, 2);
      @(negedge clk);
      checkOutput("t1_ready_a", 32'(recReady), 32'd0);
      @(negedge clk);
      checkOutput("t1_ready_b", 32'(recReady), 32'd0);
      @(negedge clk);
      checkOutput("t1_ready_c", 32'(recReady), 32'd1);

      // Time record, seq 1
      applyStimulus(2'd2, 4'd0, 8'h00, 14'h0, 48'h0123456789AB,
                    {16'h8001, 16'h0123, 16'h4567, 16'h89AB, 16'h0}, 4);
      waitIdle();
      checkOutput("t2_cnt", 32'(wordCnt), 32'd6);

      // Five markers back-to-back, seq 2,3,0,1,2
      popCycles.delete();
      applyStimulus(2'd0, 4'd0, 8'h00, 14'h0, 48'h0, {16'h0002, 64'h0}, 1);
      applyStimulus(2'd0, 4'd0, 8'h00, 14'h0, 48'h0, {16'h0003, 64'h0}, 1);
      applyStimulus(2'd0, 4'd0, 8'h00, 14'h0, 48'h0, {16'h0000, 64'h0}, 1);
      applyStimulus(2'd0, 4'd0, 8'h00, 14'h0, 48'h0, {16'h0001, 64'h0}, 1);
      applyStimulus(2'd0, 4'd0, 8'h00, 14'h0, 48'h0, {16'h0002, 64'h0}, 1);
      waitIdle();
      checkOutput("t3_words", 32'(popCycles.size()), 32'd5);
      if (popCycles.size() == 5) begin
         checkOutput("t3_rate", 32'(popCycles[4] - popCycles[0]), 32'd8);
      end
      checkOutput("t3_cnt", 32'(wordCnt), 32'd11);

      // ADC+time record, seq 3, FIFO full for four cycles after the header
      applyStimulus(2'd3, 4'hA, 8'h5A, 14'h0123, 48'hFEDCBA987654,
                    {16'hE96B, 16'h0123, 16'hFEDC, 16'hBA98, 16'h7654}, 5);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      fifoFull = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("t4_stall_en", 32'(dataOutEn), 32'd0);
      end
      fifoFull = 1'b0;
      waitIdle();
      checkOutput("t4_cnt", 32'(wordCnt), 32'd16);

      // ADC record, seq 0, with valid held and fields churning during emission
      applyStimulus(2'd1, 4'd1, 8'h02, 14'h0005, 48'h0,
                    {16'h4408, 16'h0005, 48'h0}, 2);
      recValid = 1'b1;
      recType  = 2'd3;
      recDev   = 4'hF;
      recAddr  = 8'hFF;
      recAdc   = 14'h3FFF;
      recTime  = 48'hFFFFFFFFFFFF;
      @(posedge clk);
      recAddr = 8'h77;
      @(posedge clk);
      #1;
      recValid = 1'b0;
      waitIdle();
      checkOutput("t6_cnt", 32'(wordCnt), 32'd18);

      // Reset after the second word of an ADC+time record, seq 1
      applyStimulus(2'd3, 4'd2, 8'h33, 14'h0777, 48'h111122223333,
                    {16'hC8CD, 16'h0777, 48'h0}, 2);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("t5_en", 32'(dataOutEn), 32'd0);
      checkOutput("t5_busy", 32'(busy), 32'd0);
      checkOutput("t5_cnt", 32'(wordCnt), 32'd0);
      checkOutput("t5_ready", 32'(recReady), 32'd0);
      checkOutput("t5_pending", 32'(expQ.size()), 32'd0);
      rst = 1'b0;
      applyStimulus(2'd0, 4'd5, 8'h80, 14'h0, 48'h0, {16'h1600, 64'h0}, 1);
      waitIdle();
      checkOutput("t5_cnt_after", 32'(wordCnt), 32'd1);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
